// File: rtl/cim_pkg.sv
// Shared constants and types for the CIM datapath: PE geometry, activation width,
// and the partial-sum accumulator state encoding.
package cim_pkg;

    localparam int unsigned PSUM_W   = 14;
    localparam int unsigned ACT_W    = 4;
    localparam int unsigned PE_ROWS  = 64;
    // Largest PSUM a single PE pass can produce: every row at 15 * 15.
    localparam int unsigned MAX_PSUM = PE_ROWS * 15 * 15;

    typedef enum logic {
        ACC,
        OUT
    } acc_state_e;

endpackage

// File: rtl/psum_quant.sv
// Requantizer: logical right shift of an accumulated sum followed by unsigned
// saturation to an ACT_W-bit activation. Purely combinational.
module psum_quant
    import cim_pkg::*;
#(
    parameter int unsigned IN_W    = 20,
    parameter int unsigned SHIFT_W = 5
) (
    input  logic [IN_W-1:0]    i_acc,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [ACT_W-1:0]   o_act
);

    logic [IN_W-1:0] w_q;

    always_comb begin
        w_q = '0;
        // Shifts at or beyond the input width flush everything out.
        if (32'(i_shift) < IN_W) begin
            w_q = i_acc >> i_shift;
        end
        if (|w_q[IN_W-1:ACT_W]) begin
            o_act = '1;
        end else begin
            o_act = w_q[ACT_W-1:0];
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates NUM_TILES partial sums from the PE into one saturating total, then
// holds the raw sum and its requantized activation until the consumer takes it.
module psum_accumulator
    import cim_pkg::*;
#(
    parameter int unsigned NUM_TILES = 4,
    parameter int unsigned ACC_W     = 20,
    parameter int unsigned SHIFT_W   = 5,
    localparam int unsigned TILE_W   = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               psum_valid,
    output logic               psum_ready,
    input  logic [PSUM_W-1:0]  psum_in,
    input  logic [SHIFT_W-1:0] shift_amt,
    output logic [TILE_W-1:0]  tile_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACT_W-1:0]   out_act,
    output logic [ACC_W-1:0]   out_acc,
    output logic               out_ovf
);

    acc_state_e         r_state,    w_state_next;
    logic [TILE_W-1:0]  r_tile_cnt, w_tile_cnt_next;
    logic [ACC_W-1:0]   r_acc,      w_acc_next;
    logic [SHIFT_W-1:0] r_shift,    w_shift_next;
    logic               r_ovf,      w_ovf_next;

    logic               w_accept;
    logic               w_last;
    logic [ACC_W:0]     w_psum_ext;
    logic [ACC_W:0]     w_sum;

    assign psum_ready = (r_state == ACC) || ((r_state == OUT) && out_ready);
    assign w_accept   = psum_valid && psum_ready;
    assign w_last     = (r_tile_cnt == TILE_W'(NUM_TILES - 1));
    assign w_psum_ext = {{(ACC_W + 1 - PSUM_W){1'b0}}, psum_in};
    assign w_sum      = {1'b0, r_acc} + w_psum_ext;

    always_comb begin
        w_state_next    = r_state;
        w_tile_cnt_next = r_tile_cnt;
        w_acc_next      = r_acc;
        w_shift_next    = r_shift;
        w_ovf_next      = r_ovf;

        if (w_accept) begin
            if (r_tile_cnt == '0) begin
                w_acc_next   = w_psum_ext[ACC_W-1:0];
                w_shift_next = shift_amt;
                w_ovf_next   = 1'b0;
            end else if (w_sum[ACC_W]) begin
                w_acc_next = '1;
                w_ovf_next = 1'b1;
            end else begin
                w_acc_next = w_sum[ACC_W-1:0];
            end
            w_tile_cnt_next = w_last ? '0 : r_tile_cnt + TILE_W'(1);
        end

        unique case (r_state)
            ACC: begin
                if (w_accept && w_last) begin
                    w_state_next = OUT;
                end
            end
            OUT: begin
                // A tile accepted alongside the handshake opens the next group.
                if (out_ready) begin
                    w_state_next = (w_accept && w_last) ? OUT : ACC;
                end
            end
            default: w_state_next = ACC;
        endcase

        if (flush) begin
            w_state_next    = ACC;
            w_tile_cnt_next = '0;
            w_acc_next      = '0;
            w_ovf_next      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ACC;
            r_tile_cnt <= '0;
            r_acc      <= '0;
            r_shift    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tile_cnt <= w_tile_cnt_next;
            r_acc      <= w_acc_next;
            r_shift    <= w_shift_next;
            r_ovf      <= w_ovf_next;
        end
    end

    psum_quant #(
        .IN_W    (ACC_W),
        .SHIFT_W (SHIFT_W)
    ) u_quant (
        .i_acc   (r_acc),
        .i_shift (r_shift),
        .o_act   (out_act)
    );

    assign out_valid = (r_state == OUT);
    assign out_acc   = r_acc;
    assign out_ovf   = r_ovf;
    assign tile_idx  = r_tile_cnt;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a 4-tile/20-bit instance for the main
// flow and an 8-tile/16-bit instance for accumulator saturation.
module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        flush_a, psum_valid_a, psum_ready_a, out_valid_a, out_ready_a, out_ovf_a;
    logic [13:0] psum_in_a;
    logic [4:0]  shift_amt_a;
    logic [1:0]  tile_idx_a;
    logic [3:0]  out_act_a;
    logic [19:0] out_acc_a;

    logic        flush_b, psum_valid_b, psum_ready_b, out_valid_b, out_ready_b, out_ovf_b;
    logic [13:0] psum_in_b;
    logic [4:0]  shift_amt_b;
    logic [2:0]  tile_idx_b;
    logic [3:0]  out_act_b;
    logic [15:0] out_acc_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    psum_accumulator #(.NUM_TILES(4), .ACC_W(20), .SHIFT_W(5)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_a),
        .psum_valid (psum_valid_a),
        .psum_ready (psum_ready_a),
        .psum_in    (psum_in_a),
        .shift_amt  (shift_amt_a),
        .tile_idx   (tile_idx_a),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready_a),
        .out_act    (out_act_a),
        .out_acc    (out_acc_a),
        .out_ovf    (out_ovf_a)
    );

    psum_accumulator #(.NUM_TILES(8), .ACC_W(16), .SHIFT_W(5)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_b),
        .psum_valid (psum_valid_b),
        .psum_ready (psum_ready_b),
        .psum_in    (psum_in_b),
        .shift_amt  (shift_amt_b),
        .tile_idx   (tile_idx_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b),
        .out_act    (out_act_b),
        .out_acc    (out_acc_b),
        .out_ovf    (out_ovf_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_a(input logic [13:0] v, input logic [4:0] sh);
        int n = 0;
        psum_valid_a = 1'b1;
        psum_in_a    = v;
        shift_amt_a  = sh;
        while (!psum_ready_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("a_ready_wait", 32'(n < 20), 1);
        @(negedge clk);
        psum_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [13:0] v, input logic [4:0] sh);
        int n = 0;
        psum_valid_b = 1'b1;
        psum_in_b    = v;
        shift_amt_b  = sh;
        while (!psum_ready_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("b_ready_wait", 32'(n < 20), 1);
        @(negedge clk);
        psum_valid_b = 1'b0;
    endtask

    task automatic consume_a();
        out_ready_a = 1'b1;
        @(negedge clk);
        check_eq("a_consumed", 32'(out_valid_a), 0);
        out_ready_a = 1'b0;
    endtask

    task automatic consume_b();
        out_ready_b = 1'b1;
        @(negedge clk);
        check_eq("b_consumed", 32'(out_valid_b), 0);
        out_ready_b = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        flush_a      = 1'b0; psum_valid_a = 1'b0; psum_in_a = '0; shift_amt_a = '0;
        out_ready_a  = 1'b0;
        flush_b      = 1'b0; psum_valid_b = 1'b0; psum_in_b = '0; shift_amt_b = '0;
        out_ready_b  = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(out_valid_a), 0);
        check_eq("rst_ready", 32'(psum_ready_a), 1);
        check_eq("rst_acc", 32'(out_acc_a), 0);
        check_eq("rst_act", 32'(out_act_a), 0);
        check_eq("rst_tile", 32'(tile_idx_a), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic accumulation, shift 7
        send_a(14'd100, 5'd7);
        send_a(14'd200, 5'd7);
        send_a(14'd300, 5'd7);
        check_eq("t1_tile3", 32'(tile_idx_a), 3);
        check_eq("t1_not_yet", 32'(out_valid_a), 0);
        send_a(14'd400, 5'd7);
        check_eq("t1_valid", 32'(out_valid_a), 1);
        check_eq("t1_acc", 32'(out_acc_a), 1000);
        check_eq("t1_act", 32'(out_act_a), 7);
        check_eq("t1_ovf", 32'(out_ovf_a), 0);
        check_eq("t1_tile_wrap", 32'(tile_idx_a), 0);
        consume_a();

        // Same group with shift 4 saturates the activation
        send_a(14'd100, 5'd4);
        send_a(14'd200, 5'd4);
        send_a(14'd300, 5'd4);
        send_a(14'd400, 5'd4);
        check_eq("t1b_acc", 32'(out_acc_a), 1000);
        check_eq("t1b_act", 32'(out_act_a), 15);
        consume_a();

        // Maximum PSUM
        for (int i = 0; i < 4; i++) send_a(14'd14400, 5'd12);
        check_eq("t2_acc", 32'(out_acc_a), 57600);
        check_eq("t2_act", 32'(out_act_a), 14);
        check_eq("t2_ovf", 32'(out_ovf_a), 0);
        consume_a();

        // Accumulator saturation on the 16-bit instance
        for (int i = 0; i < 8; i++) send_b(14'd14400, 5'd0);
        check_eq("t3_valid", 32'(out_valid_b), 1);
        check_eq("t3_acc", 32'(out_acc_b), 65535);
        check_eq("t3_ovf", 32'(out_ovf_b), 1);
        consume_b();
        for (int i = 0; i < 8; i++) send_b(14'd1, 5'd0);
        check_eq("t3b_acc", 32'(out_acc_b), 8);
        check_eq("t3b_ovf", 32'(out_ovf_b), 0);
        consume_b();

        // Backpressure, then handshake with a simultaneous tile
        for (int i = 0; i < 4; i++) send_a(14'd5, 5'd0);
        psum_valid_a = 1'b1;
        psum_in_a    = 14'd99;
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_ready_low", 32'(psum_ready_a), 0);
            check_eq("t4_valid_hold", 32'(out_valid_a), 1);
            check_eq("t4_acc_hold", 32'(out_acc_a), 20);
            check_eq("t4_act_hold", 32'(out_act_a), 15);
            check_eq("t4_tile_hold", 32'(tile_idx_a), 0);
            @(negedge clk);
        end
        out_ready_a = 1'b1;
        psum_in_a   = 14'd50;
        shift_amt_a = 5'd0;
        @(negedge clk);
        psum_valid_a = 1'b0;
        out_ready_a  = 1'b0;
        check_eq("t4_handoff_valid", 32'(out_valid_a), 0);
        check_eq("t4_handoff_tile", 32'(tile_idx_a), 1);
        check_eq("t4_handoff_acc", 32'(out_acc_a), 50);
        for (int i = 0; i < 3; i++) send_a(14'd10, 5'd0);
        check_eq("t4_valid", 32'(out_valid_a), 1);
        check_eq("t4_acc", 32'(out_acc_a), 80);
        consume_a();

        // Flush mid-group
        send_a(14'd500, 5'd0);
        send_a(14'd500, 5'd0);
        check_eq("t5_tile2", 32'(tile_idx_a), 2);
        flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        check_eq("t5_tile0", 32'(tile_idx_a), 0);
        check_eq("t5_acc0", 32'(out_acc_a), 0);
        for (int i = 0; i < 4; i++) send_a(14'd10, 5'd0);
        check_eq("t5_valid", 32'(out_valid_a), 1);
        check_eq("t5_acc", 32'(out_acc_a), 40);
        // Flush while a result is held
        flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        check_eq("t5_out_drop", 32'(out_valid_a), 0);
        check_eq("t5_out_acc", 32'(out_acc_a), 0);
        check_eq("t5_out_ready", 32'(psum_ready_a), 1);

        // Asynchronous reset mid-group
        send_a(14'd100, 5'd0);
        send_a(14'd200, 5'd0);
        check_eq("t6_pre_acc", 32'(out_acc_a), 300);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_valid", 32'(out_valid_a), 0);
        check_eq("t6_acc", 32'(out_acc_a), 0);
        check_eq("t6_tile", 32'(tile_idx_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("t6_ready", 32'(psum_ready_a), 1);
        send_a(14'd1, 5'd0);
        send_a(14'd2, 5'd0);
        send_a(14'd3, 5'd0);
        send_a(14'd4, 5'd0);
        check_eq("t6_fresh_valid", 32'(out_valid_a), 1);
        check_eq("t6_fresh_acc", 32'(out_acc_a), 10);
        consume_a();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
